ram_controller: RTL and testbench

//  Word-organised on-chip data RAM slave behind the unified memory dispatcher's RAM port.

---
 rtl/ram_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_ram_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_controller.sv
// ram_controller: word-organised on-chip data RAM slave for the memory dispatcher.
// Little-endian byte/half/word access, local alignment/range checking,
// programmable wait states, fully registered handshake outputs.

`ifndef MEM_WIDTH_BYTE
`define MEM_WIDTH_BYTE 2'b00
`endif
`ifndef MEM_WIDTH_HALF
`define MEM_WIDTH_HALF 2'b01
`endif
`ifndef MEM_WIDTH_WORD
`define MEM_WIDTH_WORD 2'b10
`endif
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`endif
`ifndef EXCEP_OK
`define EXCEP_OK 4'h0
`endif
`ifndef EXCEP_INVALID_MEM_READ
`define EXCEP_INVALID_MEM_READ 4'h5
`endif
`ifndef EXCEP_INVALID_MEM_WRITE
`define EXCEP_INVALID_MEM_WRITE 4'h6
`endif

module ram_controller #(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               addr_In,
  input  logic [31:0]               data_In,
  input  logic [1:0]                dataWidth_In,
  input  logic                      isRead_In,
  input  logic                      select_In,
  output logic                      finish_Out,
  output logic [31:0]               data_Out,
  output logic [`EXCEPTION_LEN-1:0] exception_Out
);

  localparam int WORDS = (2 ** ADDR_BITS) / 4;
  // Counter preload; LATENCY==0 never enters WAIT so the value is unused then.
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Request is illegal when misaligned, of reserved width, or outside the array.
  function automatic logic req_error(input logic [31:0] a, input logic [1:0] w);
    logic e;
    e = 1'b0;
    case (w)
      `MEM_WIDTH_BYTE: e = 1'b0;
      `MEM_WIDTH_HALF: e = a[0];
      `MEM_WIDTH_WORD: e = (a[1:0] != 2'b00);
      default:         e = 1'b1;
    endcase
    if ((a >> ADDR_BITS) != 32'd0) begin
      e = 1'b1;
    end else begin
      e = e;
    end
    return e;
  endfunction

  state_t r_state;
  state_t w_state_nx;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nx;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [1:0]  r_width;
  logic        r_is_read;
  logic        r_finish;
  logic [31:0] r_data_out;
  logic [`EXCEPTION_LEN-1:0] r_exc;
  logic [31:0] r_mem [0:WORDS-1];

  logic        w_capture;
  logic        w_do_access;
  logic        w_finish_nx;
  logic [31:0] w_data_nx;
  logic [`EXCEPTION_LEN-1:0] w_exc_nx;

  // Access operands come straight from the inputs in IDLE (zero-latency path),
  // otherwise from the values captured at the request edge.
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_data;
  logic [1:0]  w_acc_width;
  logic        w_acc_is_read;
  logic        w_err;
  logic [ADDR_BITS-3:0] w_idx;
  logic [31:0] w_rd_word;
  logic [31:0] w_rd_shift;
  logic [31:0] w_rd_data;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_mem_we;

  assign w_acc_addr    = (r_state == S_IDLE) ? addr_In      : r_addr;
  assign w_acc_data    = (r_state == S_IDLE) ? data_In      : r_data;
  assign w_acc_width   = (r_state == S_IDLE) ? dataWidth_In : r_width;
  assign w_acc_is_read = (r_state == S_IDLE) ? isRead_In    : r_is_read;
  assign w_err         = req_error(addr_In, dataWidth_In);
  assign w_idx         = w_acc_addr[ADDR_BITS-1:2];
  assign w_rd_word     = r_mem[w_idx];
  assign w_rd_shift    = w_rd_word >> {w_acc_addr[1:0], 3'b000};
  assign w_wdata       = w_acc_data << {w_acc_addr[1:0], 3'b000};
  assign w_mem_we      = w_do_access && !w_acc_is_read && !rst;

  // Lane extraction and byte-enable generation from width and low address bits.
  always_comb begin
    w_rd_data = 32'h0;
    w_be      = 4'b0000;
    case (w_acc_width)
      `MEM_WIDTH_BYTE: begin
        w_rd_data = {24'h0, w_rd_shift[7:0]};
        w_be      = 4'b0001 << w_acc_addr[1:0];
      end
      `MEM_WIDTH_HALF: begin
        w_rd_data = {16'h0, w_rd_shift[15:0]};
        w_be      = 4'b0011 << w_acc_addr[1:0];
      end
      `MEM_WIDTH_WORD: begin
        w_rd_data = w_rd_shift;
        w_be      = 4'b1111;
      end
      default: begin
        w_rd_data = 32'h0;
        w_be      = 4'b0000;
      end
    endcase
  end

  // Next-state and next-output decode for the IDLE/WAIT/DONE handshake.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_capture   = 1'b0;
    w_do_access = 1'b0;
    w_finish_nx = r_finish;
    w_data_nx   = r_data_out;
    w_exc_nx    = r_exc;
    case (r_state)
      S_IDLE: begin
        if (select_In) begin
          w_capture = 1'b1;
          if (w_err) begin
            w_state_nx  = S_DONE;
            w_finish_nx = 1'b1;
            w_data_nx   = 32'h0;
            w_exc_nx    = isRead_In ? `EXCEP_INVALID_MEM_READ : `EXCEP_INVALID_MEM_WRITE;
          end else if (LATENCY == 0) begin
            w_do_access = 1'b1;
            w_state_nx  = S_DONE;
            w_finish_nx = 1'b1;
            w_data_nx   = isRead_In ? w_rd_data : 32'h0;
            w_exc_nx    = `EXCEP_OK;
          end else begin
            w_state_nx = S_WAIT;
            w_cnt_nx   = LAT_M1;
          end
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!select_In) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nx = r_cnt - 4'd1;
        end else begin
          w_do_access = 1'b1;
          w_state_nx  = S_DONE;
          w_finish_nx = 1'b1;
          w_data_nx   = r_is_read ? w_rd_data : 32'h0;
          w_exc_nx    = `EXCEP_OK;
        end
      end
      S_DONE: begin
        if (!select_In) begin
          w_state_nx  = S_IDLE;
          w_finish_nx = 1'b0;
          w_data_nx   = 32'h0;
          w_exc_nx    = `EXCEP_OK;
        end else begin
          w_state_nx = S_DONE;
        end
      end
      default: begin
        w_state_nx  = S_IDLE;
        w_finish_nx = 1'b0;
        w_data_nx   = 32'h0;
        w_exc_nx    = `EXCEP_OK;
      end
    endcase
  end

  // State, wait counter, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 32'h0;
      r_data     <= 32'h0;
      r_width    <= 2'b00;
      r_is_read  <= 1'b0;
      r_finish   <= 1'b0;
      r_data_out <= 32'h0;
      r_exc      <= `EXCEP_OK;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_finish   <= w_finish_nx;
      r_data_out <= w_data_nx;
      r_exc      <= w_exc_nx;
      if (w_capture) begin
        r_addr    <= addr_In;
        r_data    <= data_In;
        r_width   <= dataWidth_In;
        r_is_read <= isRead_In;
      end
    end
  end

  // Byte-masked array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign finish_Out    = r_finish;
  assign data_Out      = r_data_out;
  assign exception_Out = r_exc;

endmodule

// File: tb/tb_ram_controller.sv
// Directed self-checking bench for ram_controller (LATENCY 1, 0 and 3 instances).

`ifndef MEM_WIDTH_BYTE
`define MEM_WIDTH_BYTE 2'b00
`endif
`ifndef MEM_WIDTH_HALF
`define MEM_WIDTH_HALF 2'b01
`endif
`ifndef MEM_WIDTH_WORD
`define MEM_WIDTH_WORD 2'b10
`endif
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`endif
`ifndef EXCEP_OK
`define EXCEP_OK 4'h0
`endif
`ifndef EXCEP_INVALID_MEM_READ
`define EXCEP_INVALID_MEM_READ 4'h5
`endif
`ifndef EXCEP_INVALID_MEM_WRITE
`define EXCEP_INVALID_MEM_WRITE 4'h6
`endif

module tb_ram_controller;

  localparam logic [1:0] WB = `MEM_WIDTH_BYTE;
  localparam logic [1:0] WH = `MEM_WIDTH_HALF;
  localparam logic [1:0] WW = `MEM_WIDTH_WORD;
  localparam logic [31:0] OK = 32'(`EXCEP_OK);
  localparam logic [31:0] ERD = 32'(`EXCEP_INVALID_MEM_READ);
  localparam logic [31:0] EWR = 32'(`EXCEP_INVALID_MEM_WRITE);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [1:0]  width = 2'b00;
  logic        is_read = 1'b0;
  logic sel_a = 1'b0, sel_b = 1'b0, sel_c = 1'b0;
  logic fin_a, fin_b, fin_c;
  logic [31:0] dout_a, dout_b, dout_c;
  logic [`EXCEPTION_LEN-1:0] exc_a, exc_b, exc_c;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_controller #(.ADDR_BITS(16), .LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .addr_In(addr), .data_In(wdata), .dataWidth_In(width),
    .isRead_In(is_read), .select_In(sel_a), .finish_Out(fin_a), .data_Out(dout_a),
    .exception_Out(exc_a));
  ram_controller #(.ADDR_BITS(16), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .addr_In(addr), .data_In(wdata), .dataWidth_In(width),
    .isRead_In(is_read), .select_In(sel_b), .finish_Out(fin_b), .data_Out(dout_b),
    .exception_Out(exc_b));
  ram_controller #(.ADDR_BITS(16), .LATENCY(3)) dut_c (
    .clk(clk), .rst(rst), .addr_In(addr), .data_In(wdata), .dataWidth_In(width),
    .isRead_In(is_read), .select_In(sel_c), .finish_Out(fin_c), .data_Out(dout_c),
    .exception_Out(exc_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic fin_of(input int w);
    case (w)
      0: return fin_a;
      1: return fin_b;
      default: return fin_c;
    endcase
  endfunction

  function automatic logic [31:0] dout_of(input int w);
    case (w)
      0: return dout_a;
      1: return dout_b;
      default: return dout_c;
    endcase
  endfunction

  function automatic logic [31:0] exc_of(input int w);
    case (w)
      0: return 32'(exc_a);
      1: return 32'(exc_b);
      default: return 32'(exc_c);
    endcase
  endfunction

  task automatic set_sel(input int w, input logic v);
    case (w)
      0: sel_a = v;
      1: sel_b = v;
      default: sel_c = v;
    endcase
  endtask

  // Starts at a negedge; returns cycles from capture edge to finish seen (99 = timeout).
  task automatic req(input int w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] wd, input logic rd,
                     output int cyc, output logic [31:0] dat, output logic [31:0] ex);
    addr = a; wdata = d; width = wd; is_read = rd;
    set_sel(w, 1'b1);
    @(posedge clk);
    cyc = 99;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (fin_of(w)) begin
        cyc = k;
        break;
      end
    end
    dat = dout_of(w);
    ex  = exc_of(w);
    // Inputs wander after capture; must be ignored.
    addr = 32'h0000_FFFC; wdata = 32'hFFFF_FFFF; width = WB; is_read = ~rd;
  endtask

  task automatic rel(input int w);
    set_sel(w, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  int cyc;
  logic [31:0] d, e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_finish", 32'(fin_a), 32'h0);
    chk("rst_data", dout_a, 32'h0);
    chk("rst_exc", 32'(exc_a), OK);
    rst = 1'b0;
    @(negedge clk);

    // 1: word write / read
    req(0, 32'h10, 32'hDEADBEEF, WW, 1'b0, cyc, d, e); rel(0);
    chk("t1_wr_cyc", 32'(cyc), 32'd2);
    chk("t1_wr_data", d, 32'h0);
    chk("t1_wr_exc", e, OK);
    req(0, 32'h10, 32'h0, WW, 1'b1, cyc, d, e);
    chk("t1_rd_clr_chk", 32'(fin_a), 32'h1);
    rel(0);
    chk("t1_rd_cyc", 32'(cyc), 32'd2);
    chk("t1_rd_data", d, 32'hDEADBEEF);
    chk("t1_rd_exc", e, OK);
    chk("t1_finish_clr", 32'(fin_a), 32'h0);
    chk("t1_data_clr", dout_a, 32'h0);

    // 2: byte write and sub-word reads
    req(0, 32'h11, 32'h000000AA, WB, 1'b0, cyc, d, e); rel(0);
    chk("t2_bw_exc", e, OK);
    req(0, 32'h10, 32'h0, WW, 1'b1, cyc, d, e); rel(0);
    chk("t2_word", d, 32'hDEADAAEF);
    req(0, 32'h12, 32'h0, WH, 1'b1, cyc, d, e); rel(0);
    chk("t2_half", d, 32'h0000DEAD);
    req(0, 32'h13, 32'h0, WB, 1'b1, cyc, d, e); rel(0);
    chk("t2_byte", d, 32'h000000DE);
    req(0, 32'h11, 32'h0, WB, 1'b1, cyc, d, e); rel(0);
    chk("t2_byte11", d, 32'h000000AA);

    // 3: misalignment
    req(0, 32'h13, 32'h0, WW, 1'b1, cyc, d, e); rel(0);
    chk("t3_mis_cyc", 32'(cyc), 32'd1);
    chk("t3_mis_exc", e, ERD);
    chk("t3_mis_data", d, 32'h0);
    req(0, 32'h11, 32'h00001234, WH, 1'b0, cyc, d, e); rel(0);
    chk("t3_hw_cyc", 32'(cyc), 32'd1);
    chk("t3_hw_exc", e, EWR);
    req(0, 32'h10, 32'h0, WW, 1'b1, cyc, d, e); rel(0);
    chk("t3_unchanged", d, 32'hDEADAAEF);

    // 4: range and reserved width
    req(0, 32'h0, 32'h11223344, WW, 1'b0, cyc, d, e); rel(0);
    req(0, 32'h10000, 32'hFFFFFFFF, WW, 1'b0, cyc, d, e); rel(0);
    chk("t4_oor_exc", e, EWR);
    chk("t4_oor_cyc", 32'(cyc), 32'd1);
    req(0, 32'h0, 32'h0, WW, 1'b1, cyc, d, e); rel(0);
    chk("t4_word0", d, 32'h11223344);
    req(0, 32'h0, 32'h0, 2'b11, 1'b1, cyc, d, e); rel(0);
    chk("t4_w11_exc", e, ERD);
    req(0, 32'h2, 32'h0, WH, 1'b1, cyc, d, e); rel(0);
    chk("t4_half2", d, 32'h00001122);

    // 5: abort during WAIT and reset during WAIT
    req(0, 32'h20, 32'hA5A5A5A5, WW, 1'b0, cyc, d, e); rel(0);
    addr = 32'h20; wdata = 32'h12345678; width = WW; is_read = 1'b0;
    sel_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sel_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_abort_fin", 32'(fin_a), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_abort_fin2", 32'(fin_a), 32'h0);
    req(0, 32'h20, 32'h0, WW, 1'b1, cyc, d, e); rel(0);
    chk("t5_abort_mem", d, 32'hA5A5A5A5);
    addr = 32'h20; wdata = 32'h0BADF00D; width = WW; is_read = 1'b0;
    sel_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_fin", 32'(fin_a), 32'h0);
    chk("t5_rst_data", dout_a, 32'h0);
    chk("t5_rst_exc", 32'(exc_a), OK);
    rst = 1'b0;
    sel_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req(0, 32'h20, 32'h0, WW, 1'b1, cyc, d, e); rel(0);
    chk("t5_rst_mem", d, 32'hA5A5A5A5);

    // 6: LATENCY 0 and 3
    req(1, 32'h40, 32'hCAFEF00D, WW, 1'b0, cyc, d, e); rel(1);
    chk("t6_l0_wr_cyc", 32'(cyc), 32'd1);
    req(1, 32'h40, 32'h0, WW, 1'b1, cyc, d, e); rel(1);
    chk("t6_l0_rd_cyc", 32'(cyc), 32'd1);
    chk("t6_l0_rd_data", d, 32'hCAFEF00D);
    req(2, 32'h40, 32'h01020304, WW, 1'b0, cyc, d, e); rel(2);
    chk("t6_l3_wr_cyc", 32'(cyc), 32'd4);
    req(2, 32'h42, 32'h0, WH, 1'b1, cyc, d, e);
    chk("t6_l3_rd_cyc", 32'(cyc), 32'd4);
    chk("t6_l3_rd_data", d, 32'h00000102);
    repeat (5) @(negedge clk);
    chk("t6_l3_hold_fin", 32'(fin_c), 32'h1);
    chk("t6_l3_hold_data", dout_c, 32'h00000102);
    chk("t6_l3_hold_exc", 32'(exc_c), OK);
    sel_c = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_l3_clr_fin", 32'(fin_c), 32'h0);
    chk("t6_l3_clr_data", dout_c, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
